// File: rtl/fir_out_conditioner_if.sv
// Sample bus between the FIR output conditioner and its neighbours.
//
// Handshake: the input side (in_valid/in_data) is a free-running strobe with
// no back-pressure, so a sample is taken on every rising clk edge where
// in_valid=1. The output side follows valid/ready. out_valid/out_data are
// driven by the producer and do not depend on out_ready. Once out_valid=1,
// out_data stays stable until the transfer happens. A transfer happens on
// every rising clk edge where out_valid=1 and out_ready=1.
interface fir_out_conditioner_if #(
  parameter int IN_W  = 40,
  parameter int OUT_W = 16
);
  logic             in_valid;
  logic [IN_W-1:0]  in_data;
  logic             out_ready;
  logic             out_valid;
  logic [OUT_W-1:0] out_data;

  // Environment side: drives FIR samples and sink ready.
  modport master (
    output in_valid, in_data, out_ready,
    input  out_valid, out_data
  );

  // Conditioner side.
  modport slave (
    input  in_valid, in_data, out_ready,
    output out_valid, out_data
  );
endinterface

// File: rtl/fir_out_conditioner.sv
// FIR output conditioner. It rounds and rescales the full-precision FIR
// accumulator output, saturates it to OUT_W bits and decimates by DECIM. The
// results go into a first-word-fall-through FIFO that drives a valid/ready
// sink. Samples that arrive while the FIFO is full are dropped and counted.
// Optional feature macro: FIR_OUT_PEAK_EN adds peak_clr/peak_abs. These track
// the peak magnitude of the written samples.
module fir_out_conditioner #(
  parameter int IN_W       = 40,
  parameter int OUT_W      = 16,
  parameter int FRAC_SHIFT = 15,
  parameter int DECIM      = 1,
  parameter int DEPTH      = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  fir_out_conditioner_if.slave bus,
  output logic                 fifo_full,
  output logic                 sat_flag,
  output logic [15:0]          drop_cnt
`ifdef FIR_OUT_PEAK_EN
  ,
  input  logic                 peak_clr,
  output logic [OUT_W-1:0]     peak_abs
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = (DECIM > 1) ? $clog2(DECIM) : 1;

  localparam logic [AW:0]             DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [PW-1:0]           PH_LAST = PW'(DECIM - 1);
  localparam logic signed [IN_W:0]    RND     = (IN_W+1)'(1) << (FRAC_SHIFT - 1);
  localparam logic signed [IN_W:0]    SAT_HI  = (IN_W+1)'((longint'(1) << (OUT_W - 1)) - 1);
  localparam logic signed [IN_W:0]    SAT_LO  = ~SAT_HI;
  localparam logic [OUT_W-1:0]        OUT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0]        OUT_MIN = {1'b1, {(OUT_W-1){1'b0}}};

  // ---------------- stage 1: round half toward +inf, rescale ----------------
  logic signed [IN_W:0] w_sum;
  logic signed [IN_W:0] w_shifted;
  logic                 r_s1_valid;
  logic signed [IN_W:0] r_s1_data;

  // The add uses one guard bit, so adding the rounding constant cannot wrap.
  assign w_sum     = $signed({bus.in_data[IN_W-1], bus.in_data}) + RND;
  assign w_shifted = w_sum >>> FRAC_SHIFT;

  // Register the rounded and rescaled sample.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s1_valid <= 1'b0;
      r_s1_data  <= '0;
    end else begin
      r_s1_valid <= bus.in_valid;
      if (bus.in_valid) r_s1_data <= w_shifted;
    end
  end

  // ---------------- stage 2: saturate and decimate ----------------
  logic             w_hi;
  logic             w_lo;
  logic [OUT_W-1:0] w_sat_val;
  logic             w_keep;
  logic [PW-1:0]    r_phase;
  logic             r_s2_valid;
  logic [OUT_W-1:0] r_s2_data;
  logic             r_sat;

  assign w_hi   = (r_s1_data > SAT_HI);
  assign w_lo   = (r_s1_data < SAT_LO);
  assign w_keep = (r_phase == '0);

  // Clamp the rescaled sample to the signed OUT_W range.
  always_comb begin
    w_sat_val = r_s1_data[OUT_W-1:0];
    if (w_hi)      w_sat_val = OUT_MAX;
    else if (w_lo) w_sat_val = OUT_MIN;
  end

  // Register the saturated sample, step the decimation phase and hold the sticky saturation flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_phase    <= '0;
      r_s2_valid <= 1'b0;
      r_s2_data  <= '0;
      r_sat      <= 1'b0;
    end else begin
      r_s2_valid <= r_s1_valid && w_keep;
      if (r_s1_valid) begin
        r_s2_data <= w_sat_val;
        r_phase   <= (r_phase == PH_LAST) ? '0 : r_phase + 1'b1;
        // Saturation is flagged even when decimation discards the sample.
        if (w_hi || w_lo) r_sat <= 1'b1;
      end
    end
  end

  // ---------------- FIFO ----------------
  logic [OUT_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic [15:0]      r_drop_cnt;
  logic             w_pop;
  logic             w_full;
  logic             w_wr;
  logic             w_drop;

  assign w_pop  = (r_count != '0) && bus.out_ready;
  assign w_full = (r_count == DEPTH_C);
  // A full FIFO still accepts a sample when a pop frees a slot on the same edge.
  assign w_wr   = r_s2_valid && (!w_full || w_pop);
  assign w_drop = r_s2_valid && !w_wr;

  // Storage array. It has no reset because out_data is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= r_s2_data;
  end

  // Update the pointers, the occupancy and the saturating drop counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_drop_cnt <= '0;
    end else begin
      if (w_wr)  r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_drop && (r_drop_cnt != 16'hFFFF)) r_drop_cnt <= r_drop_cnt + 1'b1;
    end
  end

  assign bus.out_valid = (r_count != '0);
  assign bus.out_data  = bus.out_valid ? r_mem[r_rd_ptr] : '0;
  assign fifo_full     = w_full;
  assign sat_flag      = r_sat;
  assign drop_cnt      = r_drop_cnt;

`ifdef FIR_OUT_PEAK_EN
  // ---------------- peak magnitude tracker ----------------
  logic [OUT_W-1:0] w_abs;
  logic             r_pk_v;
  logic [OUT_W-1:0] r_pk_mag;
  logic [OUT_W-1:0] r_peak;

  // Take the magnitude of the sample being written. The most negative code folds to the largest positive code.
  always_comb begin
    w_abs = r_s2_data;
    if (r_s2_data[OUT_W-1]) w_abs = (r_s2_data == OUT_MIN) ? OUT_MAX : (~r_s2_data + 1'b1);
  end

  // Capture the written magnitude, then fold it into the peak one cycle later. A clear overrides the update.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pk_v   <= 1'b0;
      r_pk_mag <= '0;
      r_peak   <= '0;
    end else begin
      r_pk_v   <= w_wr;
      r_pk_mag <= w_abs;
      if (peak_clr)                          r_peak <= '0;
      else if (r_pk_v && (r_pk_mag > r_peak)) r_peak <= r_pk_mag;
    end
  end

  assign peak_abs = r_peak;
`endif

endmodule

// File: tb/tb_fir_out_conditioner.sv
// Self-checking bench for fir_out_conditioner: directed table, corner sequences, randomized model check.
module tb_fir_out_conditioner;
  localparam int IN_W  = 40;
  localparam int OUT_W = 16;
  localparam int DEPTH = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        fifo_full1, sat_flag1, fifo_full4, sat_flag4;
  logic [15:0] drop_cnt1, drop_cnt4;

  fir_out_conditioner_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus1 ();
  fir_out_conditioner_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus4 ();

`ifdef FIR_OUT_PEAK_EN
  logic              peak_clr = 1'b0;
  logic [OUT_W-1:0]  peak_abs1, peak_abs4;
`endif

  fir_out_conditioner #(.IN_W(IN_W), .OUT_W(OUT_W), .FRAC_SHIFT(15), .DECIM(1), .DEPTH(DEPTH)) u_dut1 (
    .clk(clk), .rst(rst), .bus(bus1),
    .fifo_full(fifo_full1), .sat_flag(sat_flag1), .drop_cnt(drop_cnt1)
`ifdef FIR_OUT_PEAK_EN
    , .peak_clr(peak_clr), .peak_abs(peak_abs1)
`endif
  );

  fir_out_conditioner #(.IN_W(IN_W), .OUT_W(OUT_W), .FRAC_SHIFT(15), .DECIM(4), .DEPTH(DEPTH)) u_dut4 (
    .clk(clk), .rst(rst), .bus(bus4),
    .fifo_full(fifo_full4), .sat_flag(sat_flag4), .drop_cnt(drop_cnt4)
`ifdef FIR_OUT_PEAK_EN
    , .peak_clr(peak_clr), .peak_abs(peak_abs4)
`endif
  );

  // ---------------- scoreboard state ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [OUT_W-1:0] exp_q[$];

  task automatic check(input string name, input logic [39:0] got, input logic [39:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: round half up of x/2^15, then clamp to signed 16 bits.
  function automatic logic [15:0] ref_cond(input longint x, output bit sat);
    longint v, q;
    v = x + 16384;
    if (v >= 0) q = v / 32768;
    else        q = -((-v + 32767) / 32768);
    sat = 1'b0;
    if (q > 32767)       begin q = 32767;  sat = 1'b1; end
    else if (q < -32768) begin q = -32768; sat = 1'b1; end
    return 16'(q);
  endfunction

  // ---------------- driver ----------------
  task automatic push1(input logic [39:0] d);
    bus1.in_valid = 1'b1;
    bus1.in_data  = d;
    tick();
    bus1.in_valid = 1'b0;
  endtask

  typedef struct {
    logic [39:0] din;
    logic [15:0] dout;
    logic        sat;
  } vec_t;

  vec_t tbl[7];

  // Random-phase model state.
  bit          p1_v, p2_v, m_sat;
  longint      p1_d;
  logic [15:0] p2_d;
  int          m_idx, m_drop;

  initial begin
    logic [15:0] got4[$];
    logic [39:0] d40;
    longint      x;
    bit          s;
    bit          iv, rdy, pop;

    bus1.in_valid = 1'b0; bus1.in_data = '0; bus1.out_ready = 1'b0;
    bus4.in_valid = 1'b0; bus4.in_data = '0; bus4.out_ready = 1'b0;

    // ---- reset with random inputs ----
    for (int i = 0; i < 4; i++) begin
      bus1.in_valid  = 1'($urandom_range(0, 1));
      bus1.in_data   = {8'($urandom), $urandom};
      bus1.out_ready = 1'($urandom_range(0, 1));
      tick();
    end
    check("rst_out_valid", bus1.out_valid, 0);
    check("rst_out_data",  bus1.out_data, 0);
    check("rst_sat",       sat_flag1, 0);
    check("rst_drop",      drop_cnt1, 0);
    check("rst_full",      fifo_full1, 0);
    bus1.in_valid = 1'b0; bus1.out_ready = 1'b1;
    rst = 1'b1;
    tick(); tick(); tick();
    check("post_rst_empty", bus1.out_valid, 0);

    // ---- rounding / saturation table ----
    tbl[0] = '{40'd16384,      16'h0001, 1'b0};
    tbl[1] = '{40'd16383,      16'h0000, 1'b0};
    tbl[2] = '{-40'sd16384,    16'h0000, 1'b0};
    tbl[3] = '{-40'sd16385,    16'hFFFF, 1'b0};
    tbl[4] = '{40'h0080000000, 16'h7FFF, 1'b1};
    tbl[5] = '{40'hFF80000000, 16'h8000, 1'b1};
    tbl[6] = '{40'd163840,     16'h0005, 1'b1};
    for (int i = 0; i < 7; i++) begin
      push1(tbl[i].din);
      check("tbl_lat1", bus1.out_valid, 0);
      tick();
      check("tbl_lat2", bus1.out_valid, 0);
      tick();
      check("tbl_valid", bus1.out_valid, 1);
      check("tbl_data",  bus1.out_data, tbl[i].dout);
      check("tbl_sat",   sat_flag1, tbl[i].sat);
      tick();
      check("tbl_popped", bus1.out_valid, 0);
    end

    // ---- decimation by 4 ----
    bus4.out_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      bus4.in_valid = 1'b1;
      bus4.in_data  = 40'(k * 32768);
      tick();
      if (bus4.out_valid) got4.push_back(bus4.out_data);
    end
    bus4.in_valid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus4.out_valid) got4.push_back(bus4.out_data);
    end
    check("decim_count", got4.size(), 2);
    if (got4.size() == 2) begin
      check("decim_first",  got4[0], 1);
      check("decim_second", got4[1], 5);
    end

    // ---- overflow: 10 samples into a stalled FIFO ----
    bus1.out_ready = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      bus1.in_valid = 1'b1;
      bus1.in_data  = 40'(k * 32768);
      tick();
      if (k == 9)  check("ovf_not_full", fifo_full1, 0);
      if (k == 10) check("ovf_full",     fifo_full1, 1);
    end
    bus1.in_valid = 1'b0;
    tick(); tick(); tick();
    check("ovf_drop", drop_cnt1, 2);
    check("ovf_hold_data", bus1.out_data, 1);
    bus1.out_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      check("ovf_drain_valid", bus1.out_valid, 1);
      check("ovf_drain_data",  bus1.out_data, 40'(k));
      tick();
    end
    check("ovf_empty", bus1.out_valid, 0);

    // ---- full FIFO with a pop on the same edge as the write ----
    bus1.out_ready = 1'b0;
    for (int k = 11; k <= 18; k++) push1(40'(k * 32768));
    tick(); tick();
    check("fp_full", fifo_full1, 1);
    push1(40'(19 * 32768));
    tick();
    bus1.out_ready = 1'b1;
    tick();
    bus1.out_ready = 1'b0;
    check("fp_still_full", fifo_full1, 1);
    check("fp_drop_same",  drop_cnt1, 2);
    check("fp_head",       bus1.out_data, 12);
    bus1.out_ready = 1'b1;
    for (int k = 12; k <= 19; k++) begin
      check("fp_drain_valid", bus1.out_valid, 1);
      check("fp_drain_data",  bus1.out_data, 40'(k));
      tick();
    end
    check("fp_empty", bus1.out_valid, 0);

    // ---- asynchronous reset with 5 entries ----
    bus1.out_ready = 1'b0;
    for (int k = 21; k <= 25; k++) push1(40'(k * 32768));
    tick(); tick();
    check("ar_filled", bus1.out_valid, 1);
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check("ar_valid_now", bus1.out_valid, 0);
    check("ar_data_now",  bus1.out_data, 0);
    check("ar_drop_now",  drop_cnt1, 0);
    tick();
    rst = 1'b1;
    bus1.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("ar_no_stale", bus1.out_valid, 0);
    end

    // ---- randomized run against the reference model ----
    rst = 1'b0;
    tick();
    rst = 1'b1;
    exp_q.delete();
    p1_v = 0; p2_v = 0; m_sat = 0; m_idx = 0; m_drop = 0; p1_d = 0; p2_d = '0;
    for (int c = 0; c < 2000; c++) begin
      iv = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0: x = longint'($urandom_range(0, 2097152)) - 1048576;
        1: x = (($urandom_range(0, 1) == 1) ? (longint'(1) << 31) : -(longint'(1) << 31))
               + longint'($urandom_range(0, 200000)) - 100000;
        2: begin
             d40 = {8'($urandom), $urandom};
             x = longint'($signed(d40));
           end
        default: x = (longint'($urandom_range(0, 2000)) - 1000) * 16384 + longint'($urandom_range(0, 2)) - 1;
      endcase
      if (((c / 200) % 2) == 1) rdy = ($urandom_range(0, 9) < 2);
      else                      rdy = ($urandom_range(0, 9) < 8);
      bus1.in_valid  = iv;
      bus1.in_data   = 40'(x);
      bus1.out_ready = rdy;
      tick();
      // Model the edge that just happened.
      pop = (exp_q.size() > 0) && rdy;
      if (pop) void'(exp_q.pop_front());
      if (p2_v) begin
        if (exp_q.size() < DEPTH) exp_q.push_back(p2_d);
        else if (m_drop < 65535) m_drop++;
      end
      p2_v = p1_v;
      if (p1_v) begin
        p2_d = ref_cond(p1_d, s);
        if (s) m_sat = 1'b1;
        m_idx++;
      end
      p1_v = iv;
      p1_d = x;
      check("rnd_valid", bus1.out_valid, (exp_q.size() > 0));
      if (exp_q.size() > 0) check("rnd_data", bus1.out_data, exp_q[0]);
      check("rnd_full", fifo_full1, (exp_q.size() == DEPTH));
      check("rnd_drop", drop_cnt1, 40'(m_drop));
      check("rnd_sat",  sat_flag1, m_sat);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/fir_out_conditioner.md
Name: fir_out_conditioner

Overview:
- Sits directly downstream of the 50th-order FIR filter inside top and consumes its full-precision accumulator output.
- Rounds and rescales each sample from Q-format accumulator width to output width, saturates it, and decimates by a programmable factor.
- Buffers results in a small first-word-fall-through FIFO with a valid/ready interface toward the sink (DAC model / capture logic).
- The FIR free-runs and is never back-pressured; if the FIFO is full, the sample is dropped and counted.

Parameters:
- IN_W, 40, FIR accumulator width (signed).
- OUT_W, 16, output sample width (signed).
- FRAC_SHIFT, 15, right-shift applied after rounding (Q15 coefficients); must be at least 1.
- DECIM, 1, keep one of every DECIM accepted samples; must be at least 1.
- DEPTH, 8, FIFO entries; power of two, at least 2.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous active-low reset; block is held in reset while rst=0.
- in_valid  input  1  FIR output sample valid, single-cycle strobe.
- in_data  input  IN_W  FIR output sample, two's complement.
- out_ready  input  1  sink ready.
- out_valid  output  1  FIFO head valid.
- out_data  output  OUT_W  FIFO head sample.
- fifo_full  output  1  FIFO holds DEPTH entries.
- sat_flag  output  1  sticky flag: set when any sample saturated; cleared only by reset.
- drop_cnt  output  16  count of kept samples lost to a full FIFO; saturates at 0xFFFF.

Behaviour:
- Reset (rst=0, asynchronous): all outputs 0, FIFO empty, pointers 0, decimation phase 0, pipeline valids 0.
- Stage 1 (registered), rounding:
  - sum = in_data + 2^(FRAC_SHIFT-1), computed in IN_W+1 bits so the addition cannot wrap.
  - shifted = sum >>> FRAC_SHIFT (arithmetic shift). This rounds half toward +inf.
- Stage 2 (registered), saturation:
  - shifted > 2^(OUT_W-1)-1 gives 0x7FFF (for OUT_W=16).
  - shifted < -2^(OUT_W-1) gives 0x8000.
  - Any clamp sets sat_flag, including on samples later discarded by decimation.
- Decimation, applied at stage 2:
  - A phase counter advances on each stage-2 valid and wraps from DECIM-1 to 0.
  - Only samples at phase 0 are kept, so the first sample after reset is kept.
  - With DECIM=1 every sample is kept.
- FIFO write:
  - A kept sample is written on the cycle after stage 2, giving 2 cycles from in_valid to write.
  - The write succeeds if count<DEPTH, or if count==DEPTH and a pop occurs in the same cycle (count unchanged).
  - Otherwise the sample is discarded and drop_cnt increments.
- FIFO read:
  - out_valid = (count>0); out_data = mem[rd_ptr], first-word fall-through.
  - Pop occurs when out_valid && out_ready.
  - With an empty FIFO, out_valid rises 3 clk edges after the in_valid edge.
  - A simultaneous push and pop on an empty FIFO is impossible, because out_valid=0 means there is no pop.
- Pointers are log2(DEPTH) bits and wrap naturally. count is log2(DEPTH)+1 bits. fifo_full = (count==DEPTH).
- out_data is held stable while out_valid=1 and out_ready=0.
- Sample order is preserved, with no duplication.
- Reset mid-operation: FIFO contents are discarded, out_valid drops immediately (asynchronously), and in-flight pipeline samples are lost.

Optional Feature:
- Macro FIR_OUT_PEAK_EN.
- Defined:
  - Adds input peak_clr (1) and output peak_abs (OUT_W).
  - peak_abs tracks the maximum |sample| of kept samples at FIFO write; |0x8000| is treated as 0x7FFF.
  - Updated one cycle after the write.
  - peak_clr=1 synchronously zeroes it; clear wins over a simultaneous update.
  - Reset value 0.
- Undefined: neither port exists and no peak logic is synthesized.

Test Plan (IN_W=40, OUT_W=16, FRAC_SHIFT=15):
- Reset: rst=0 with random inputs -> out_valid=0, out_data=0, sat_flag=0, drop_cnt=0, fifo_full=0. After release the FIFO is empty.
- Rounding, out_ready=1:
  - in_data=16384 -> out_data=0x0001, out_valid 3 cycles after in_valid.
  - 16383 -> 0x0000.
  - -16384 -> 0x0000.
  - -16385 -> 0xFFFF.
- Saturation: in_data=2^31 -> 0x7FFF and sat_flag=1; in_data=-2^31 -> 0x8000; sat_flag stays 1 afterward.
- Decimation, DECIM=4: eight consecutive in_valid with in_data=k*2^15 for k=1..8 -> exactly two outputs, 1 then 5.
- Overflow, DEPTH=8:
  - out_ready=0 with 10 kept samples 1..10 -> fifo_full=1 after the 8th, drop_cnt=2.
  - Then out_ready=1 -> outputs 1..8 in order, then out_valid=0.
- Full with simultaneous pop: FIFO full, out_ready=1, new kept sample arrives -> accepted, count stays 8, drop_cnt unchanged. Also: rst=0 pulse with 5 entries -> out_valid=0 at once, and no stale data after release.
